// File: rtl/valid_pkg.sv
// Protocol constants shared by both ends of the single-cycle valid pulse link.
package valid_pkg;

  typedef enum logic [1:0] {
    CHK_LOW   = 2'b00,
    CHK_HIGH  = 2'b01,
    CHK_STUCK = 2'b10
  } chk_state_t;

  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_MAX_PEND = 15;

endpackage

// File: rtl/valid_pulse_checker.sv
// Pulse-width checker: turns each rising level of valid_in into one event
// strobe and flags pulses held longer than one cycle.
module valid_pulse_checker
  import valid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic       clr_err,
  output logic       evt_o,
  output logic       proto_err_o,
  output chk_state_t state_o
);

  chk_state_t state_q, state_d;
  logic       proto_err_q, proto_err_d;

  always_comb begin
    state_d     = state_q;
    evt_o       = 1'b0;
    proto_err_d = proto_err_q & ~clr_err;
    case (state_q)
      CHK_LOW: begin
        if (valid_in) begin
          evt_o   = 1'b1;
          state_d = CHK_HIGH;
        end
      end
      CHK_HIGH: begin
        if (valid_in) begin
          proto_err_d = 1'b1;
          state_d     = CHK_STUCK;
        end else begin
          state_d = CHK_LOW;
        end
      end
      CHK_STUCK: begin
        if (!valid_in) state_d = CHK_LOW;
      end
      default: state_d = CHK_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CHK_LOW;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign state_o     = state_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: rtl/valid_pulse_receiver.sv
// Receiver for the single-cycle valid pulse protocol: buffers events in a
// saturating counter and hands them downstream over valid/ready.
module valid_pulse_receiver
  import valid_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MAX_PEND = DEF_MAX_PEND
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             proto_err,
  input  logic             clr_err,
  output logic [1:0]       chk_state
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

  logic             evt;
  logic             deq;
  chk_state_t       chk_state_w;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;

  valid_pulse_checker u_chk (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .clr_err     (clr_err),
    .evt_o       (evt),
    .proto_err_o (proto_err),
    .state_o     (chk_state_w)
  );

  // Simultaneous accept and dequeue cancel out, even at saturation.
  always_comb begin
    deq         = out_valid_q & out_ready;
    pending_d   = pending_q;
    overflow_d  = overflow_q & ~clr_err;
    case ({evt, deq})
      2'b10: begin
        if (pending_q < MAX_CNT) pending_d = pending_q + 1'b1;
        else                     overflow_d = 1'b1;
      end
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
    out_valid_d = (pending_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pending   = pending_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign chk_state = chk_state_w;

endmodule

// File: tb/tb_valid_pulse_receiver.sv
// Bench for valid_pulse_receiver: directed scenarios plus random traffic
// compared against an event-counting reference model.
module tb_valid_pulse_receiver;

  localparam int CNT_W    = 4;
  localparam int MAX_PEND = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             proto_err;
  logic             clr_err = 1'b0;
  logic [1:0]       chk_state;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pend = 0;
  int m_ovf  = 0;
  int m_perr = 0;
  int m_run  = 0;   // consecutive high cycles of valid_in seen since reset

  always #5 clk = ~clk;

  valid_pulse_receiver #(.CNT_W(CNT_W), .MAX_PEND(MAX_PEND)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow),
    .proto_err (proto_err),
    .clr_err   (clr_err),
    .chk_state (chk_state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_chk;
    exp_chk = (m_run == 0) ? 0 : (m_run == 1) ? 1 : 2;
    check("pending",   int'(pending),   m_pend);
    check("out_valid", int'(out_valid), (m_pend != 0) ? 1 : 0);
    check("overflow",  int'(overflow),  m_ovf);
    check("proto_err", int'(proto_err), m_perr);
    check("chk_state", int'(chk_state), exp_chk);
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic v, input logic rdy, input logic c);
    int acc, deq, perr_set, ovf_set;
    rst = r; valid_in = v; out_ready = rdy; clr_err = c;
    @(posedge clk);
    if (r) begin
      m_pend = 0; m_ovf = 0; m_perr = 0; m_run = 0;
    end else begin
      acc      = (v && m_run == 0) ? 1 : 0;
      perr_set = (v && m_run == 1) ? 1 : 0;
      deq      = (rdy && m_pend > 0) ? 1 : 0;
      ovf_set  = 0;
      if (acc && !deq) begin
        if (m_pend < MAX_PEND) m_pend++;
        else ovf_set = 1;
      end else if (deq && !acc) begin
        m_pend--;
      end
      m_ovf  = (ovf_set || (m_ovf && !c)) ? 1 : 0;
      m_perr = (perr_set || (m_perr && !c)) ? 1 : 0;
      m_run  = v ? m_run + 1 : 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_pending", int'(pending), 0);

    // Single legal pulse
    step(0, 1, 0, 0);
    check("pulse_pending", int'(pending), 1);
    check("pulse_chk_high", int'(chk_state), 1);
    step(0, 0, 0, 0);

    // Level held for four cycles counts once and raises proto_err
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("hold_perr", int'(proto_err), 1);
    check("hold_chk_stuck", int'(chk_state), 2);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("hold_pending", int'(pending), 2);

    // clr_err clears proto_err; drain then saturate with 16 pulses
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("drained", int'(out_valid), 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    check("sat_pending", int'(pending), 15);
    check("sat_overflow", int'(overflow), 1);
    step(0, 0, 0, 1);
    check("clr_overflow", int'(overflow), 0);
    check("clr_keeps_pending", int'(pending), 15);

    // Accept and dequeue together at saturation
    step(0, 1, 1, 0);
    check("acc_deq_full", int'(pending), 15);
    check("acc_deq_no_ovf", int'(overflow), 0);
    step(0, 0, 1, 0);
    check("deq_only", int'(pending), 14);

    // Reset mid-operation while valid_in high; next high cycle is accepted
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rst_mid_pending", int'(pending), 0);
    step(0, 1, 0, 0);
    check("post_rst_accept", int'(pending), 1);
    step(0, 0, 0, 0);

    // Three pulses then continuous drain
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    check("drain_empty", int'(out_valid), 0);

    // Random traffic, including stuck levels, clears and occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/valid_pulse_receiver.md
Name: valid_pulse_receiver

Overview:
Receiving end of the single-cycle valid pulse protocol used by the button one-shot front end. Captures each valid pulse as one event and buffers events in a saturating pending counter. Hands events to a downstream consumer through a valid/ready handshake. Flags protocol violations (pulse wider than one cycle) and event loss (overflow) with sticky status bits.

Parameters:
CNT_W, 4, width of the pending-event counter and the pending port
MAX_PEND, 15, saturation level of the pending counter; must be <= 2**CNT_W-1 and >= 1

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
valid_in  input  1  event pulse from producer; legal pulse is high for exactly one cycle
out_valid  output  1  at least one event pending for downstream
out_ready  input  1  downstream accepts one event when high together with out_valid
pending  output  CNT_W  current number of buffered events
overflow  output  1  sticky: an event was dropped because the counter was full
proto_err  output  1  sticky: valid_in was high for two or more consecutive cycles
clr_err  input  1  clears overflow and proto_err
chk_state  output  2  checker state, for test visibility

Behaviour:
- Reset (rst=1 at a clk edge): pending=0, out_valid=0, overflow=0, proto_err=0, chk_state=CHK_LOW. The reset takes effect mid-operation and discards buffered events.
- Pulse checker FSM. Encodings: CHK_LOW=2'b00, CHK_HIGH=2'b01, CHK_STUCK=2'b10; 2'b11 is illegal and recovers to CHK_LOW.
  - CHK_LOW: if valid_in=1, accept one event and go to CHK_HIGH; otherwise stay in CHK_LOW.
  - CHK_HIGH: if valid_in=1, set proto_err, accept no event, and go to CHK_STUCK; otherwise go to CHK_LOW.
  - CHK_STUCK: if valid_in=1, stay in CHK_STUCK with no new event; otherwise go to CHK_LOW.
  - Result: a held level counts as exactly one event. A new event needs valid_in to be low for at least one cycle.
  - valid_in high in the first cycle after reset release is accepted as an event.
- Handshake:
  - out_valid is registered and equals (pending != 0). Its update follows the same edge as pending.
  - A dequeue occurs in a cycle where out_valid=1 and out_ready=1.
  - out_ready is ignored while out_valid=0.
- Counter update per cycle (acc = event accepted, deq = dequeue):
  - acc and not deq: if pending < MAX_PEND, pending+1; else hold and set overflow.
  - deq and not acc: pending-1.
  - acc and deq: pending unchanged, no overflow, including when pending = MAX_PEND.
  - neither: hold.
- Latency: event accepted at edge N gives pending/out_valid updated after edge N. The earliest dequeue is in cycle N+1.
- Sticky flags: clr_err=1 clears overflow and proto_err at the next edge. If a set condition occurs in the same cycle as clr_err, set wins.
- No combinational path from valid_in or out_ready to any output.

Decomposition:
- Shared package valid_pkg holds:
  - CHK_LOW, CHK_HIGH, CHK_STUCK encodings and the 2-bit chk_state type;
  - default CNT_W and MAX_PEND constants.
- The package is shared with the one-shot front end, so both ends agree on the protocol.
- One natural sub-module, valid_pulse_checker: the 3-state FSM plus proto_err, producing a single-cycle event strobe. Counter, handshake and overflow logic stay in the top level.

Test Plan:
- Reset, then valid_in=1 for 1 cycle with out_ready=0 -> pending=1 and out_valid=1 one cycle later, chk_state 00->01->00, proto_err=0.
- valid_in held high for 4 cycles with out_ready=0 -> pending=1, proto_err=1 from the second high cycle, chk_state 01 then 10 then 00 after release.
- 16 isolated pulses (1 high, 1 low) with out_ready=0, MAX_PEND=15 -> pending saturates at 15, overflow=1 after the 16th pulse; then clr_err=1 -> overflow=0 with pending still 15.
- pending=15, out_ready=1 and a new pulse in the same cycle -> pending stays 15, overflow stays 0. Next cycle, out_ready=1 with no pulse -> pending=14.
- 3 pulses buffered, then out_ready=1 continuously -> out_valid high for exactly 3 cycles, pending 3->2->1->0, out_valid=0 after the last dequeue.
- pending=5, proto_err=1, rst=1 for one cycle while valid_in=1 -> all outputs 0 after the reset edge. valid_in still high in the first post-reset cycle is accepted: pending=1.
